// File: rtl/ibex_multdiv_requester.sv
// ibex_multdiv_requester: holds one multiply/divide request for the multdiv block, owns its intermediate registers and shared adder, and returns the result
module ibex_multdiv_requester #(
  parameter logic DataIndTiming = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic        dit_en_i,
  input  logic        kill_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  output logic        md_dit_o,
  input  logic [32:0] md_operand_a_i,
  input  logic [32:0] md_operand_b_i,
  output logic [33:0] alu_adder_ext_o,
  output logic [31:0] alu_adder_o,
  output logic        equal_to_zero_o,
  input  logic [33:0] imd_val_d_i [2],
  input  logic [1:0]  imd_val_we_i,
  output logic [33:0] imd_val_q_o [2],
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        md_ready_o
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d, sm_q, sm_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        dit_q, dit_d, drop_q, drop_d, drop_now, accept, busy;
  assign accept   = state_q == IDLE && req_valid_i;
  assign busy     = state_q == BUSY;
  // a kill arriving in the same cycle as md_valid_i still discards the result
  assign drop_now = drop_q | kill_i;
  always_comb begin
    state_d = state_q;
    op_d    = accept ? req_op_i : op_q;
    sm_d    = accept ? req_signed_mode_i : sm_q;
    a_d     = accept ? req_a_i : a_q;
    b_d     = accept ? req_b_i : b_q;
    dit_d   = accept ? dit_en_i : dit_q;
    drop_d  = busy ? drop_now && !md_valid_i : drop_q;
    res_d   = busy && md_valid_i && !drop_now ? md_result_i : res_q;
    if (accept) state_d = BUSY;
    if (busy && md_valid_i) state_d = drop_now ? IDLE : RESP;
    if (state_q == RESP && (rsp_ready_i || kill_i)) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      sm_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      dit_q   <= DataIndTiming;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sm_q    <= sm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      dit_q   <= dit_d;
      drop_q  <= drop_d;
    end
  end
  for (genvar k = 0; k < 2; k++) begin : g_imd
    always_ff @(posedge clk_i) begin
      if (rst_i) imd_val_q_o[k] <= '0;
      else if (imd_val_we_i[k]) imd_val_q_o[k] <= imd_val_d_i[k];
    end
  end
  assign req_ready_o      = state_q == IDLE;
  assign rsp_valid_o      = state_q == RESP && !kill_i;
  assign rsp_result_o     = res_q;
  assign mult_en_o        = busy && !op_q[1];
  assign mult_sel_o       = busy && !op_q[1];
  assign div_en_o         = busy && op_q[1];
  assign div_sel_o        = busy && op_q[1];
  assign md_ready_o       = busy;
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = sm_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;
  assign md_dit_o         = dit_q;
  assign alu_adder_ext_o  = {1'b0, md_operand_a_i} + {1'b0, md_operand_b_i};
  assign alu_adder_o      = alu_adder_ext_o[32:1];
  assign equal_to_zero_o  = alu_adder_o == 32'h0;
endmodule

// File: tb/tb_ibex_multdiv_requester.sv
// tb_ibex_multdiv_requester: directed scoreboard bench with a behavioural multdiv stub
module tb_ibex_multdiv_requester;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready, dit_en, kill, rsp_valid, rsp_ready;
  logic [1:0] req_op, req_sm, md_operator, md_sm, imd_we;
  logic [31:0] req_a, req_b, rsp_result, md_op_a, md_op_b, md_result, alu_adder;
  logic mult_en, div_en, mult_sel, div_sel, md_dit, eq0, md_valid, md_ready;
  logic [32:0] opa, opb;
  logic [33:0] adder_ext;
  logic [33:0] imd_d [2];
  logic [33:0] imd_q [2];
  int tests = 0, fails = 0, cnt, lat, cyc;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  ibex_multdiv_requester dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_signed_mode_i(req_sm), .req_a_i(req_a), .req_b_i(req_b),
    .dit_en_i(dit_en), .kill_i(kill), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .mult_en_o(mult_en), .div_en_o(div_en),
    .mult_sel_o(mult_sel), .div_sel_o(div_sel), .md_operator_o(md_operator),
    .md_signed_mode_o(md_sm), .md_op_a_o(md_op_a), .md_op_b_o(md_op_b), .md_dit_o(md_dit),
    .md_operand_a_i(opa), .md_operand_b_i(opb), .alu_adder_ext_o(adder_ext),
    .alu_adder_o(alu_adder), .equal_to_zero_o(eq0), .imd_val_d_i(imd_d),
    .imd_val_we_i(imd_we), .imd_val_q_o(imd_q), .md_valid_i(md_valid),
    .md_result_i(md_result), .md_ready_o(md_ready)
  );

  function automatic logic [31:0] model(input logic [1:0] op, sm, input logic [31:0] a, b);
    logic [63:0] xa, xb, p;
    xa = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
    xb = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    if (!op[1]) return op[0] ? p[63:32] : p[31:0];
    if (b == 32'h0) return op[0] ? a : 32'hFFFFFFFF;
    if (sm == 2'b11) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return op[0] ? 32'h0 : a;
      return op[0] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end
    return op[0] ? a % b : a / b;
  endfunction

  // multdiv stand-in: full iteration count under DIT, short otherwise
  always_comb lat = md_dit ? 34 : (div_en && md_op_b == 32'h0) ? 2 : 6;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 0; md_valid <= 1'b0; md_result <= '0;
    end else if (md_valid) begin
      if (md_ready) begin md_valid <= 1'b0; cnt <= 0; end
    end else if (mult_en || div_en) begin
      if (cnt == lat - 1) begin
        md_valid  <= 1'b1;
        md_result <= model(md_operator, md_sm, md_op_a, md_op_b);
      end else cnt <= cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, sm, input logic [31:0] a, b, input logic dit);
    req_valid = 1'b1; req_op = op; req_sm = sm; req_a = a; req_b = b; dit_en = dit;
  endtask

  task automatic start_op(input logic [1:0] op, sm, input logic [31:0] a, b,
                          input logic dit, kill_acc, output int n);
    logic stable;
    drive_req(op, sm, a, b, dit);
    kill = kill_acc;
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op; dit_en = ~dit;
    chk("en_after_accept", op[1] ? div_en : mult_en, 1);
    chk("sel_after_accept", op[1] ? div_sel : mult_sel, 1);
    chk("other_en_low", op[1] ? mult_en : div_en, 0);
    chk("md_ready_busy", md_ready, 1);
    chk("req_ready_busy", req_ready, 0);
    chk("md_op_a", md_op_a, a);
    chk("md_op_b", md_op_b, b);
    chk("md_operator", md_operator, op);
    chk("md_signed", md_sm, sm);
    chk("md_dit", md_dit, dit);
    stable = 1'b1;
    n = 1;
    while (!md_valid && n < 300) begin
      @(negedge clk);
      n++;
      stable &= md_op_a === a && md_op_b === b && md_operator === op && md_dit === dit;
    end
    chk("md_valid_timeout", md_valid, 1);
    chk("md_stable_busy", stable, 1);
    @(negedge clk);
    chk("rsp_valid_latency", rsp_valid, 1);
  endtask

  task automatic finish_rsp(input int bp);
    logic [31:0] e;
    e = sb.size() != 0 ? sb.pop_front() : 32'hDEADBEEF;
    for (int i = 0; i < bp; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, e);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_en_low", mult_en | div_en, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, e);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_rsp", req_ready, 1);
    chk("rsp_valid_cleared", rsp_valid, 0);
  endtask

  task automatic run_op(input logic [1:0] op, sm, input logic [31:0] a, b, input logic dit,
                        input logic kill_acc, input int bp, input logic [31:0] exp, output int n);
    sb.push_back(exp);
    start_op(op, sm, a, b, dit, kill_acc, n);
    finish_rsp(bp);
  endtask

  initial begin
    logic seen;
    req_valid = 0; req_op = 0; req_sm = 0; req_a = 0; req_b = 0; dit_en = 0; kill = 0;
    rsp_ready = 0; opa = 0; opb = 0; imd_we = 0; imd_d[0] = 0; imd_d[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_en", {mult_en, div_en, mult_sel, div_sel, md_ready}, 0);
    chk("rst_imd0", imd_q[0], 0);
    chk("rst_imd1", imd_q[1], 0);
    chk("rst_latched", {md_operator, md_sm, md_op_a, md_op_b, md_dit}, 0);
    chk("rst_result", rsp_result, 0);
    rst = 1'b0;
    opa = 33'h1_FFFF_FFFF; opb = 33'h1;
    #1;
    chk("adder_ext_carry", adder_ext, 34'h2_0000_0000);
    chk("adder_carry", alu_adder, 0);
    chk("eq0_carry", eq0, 1);
    opa = 33'h2; opb = 33'h4;
    #1;
    chk("adder_ext", adder_ext, 34'h6);
    chk("adder", alu_adder, 32'h3);
    chk("eq0", eq0, 0);
    @(negedge clk);
    imd_d[0] = 34'h2_ABCD_0123; imd_d[1] = 34'h1_5555_AAAA; imd_we = 2'b01;
    @(negedge clk);
    imd_we = 2'b00;
    chk("imd0_write", imd_q[0], 34'h2_ABCD_0123);
    chk("imd1_held", imd_q[1], 0);
    run_op(2'd0, 2'b00, 32'd7, 32'd6, 1'b0, 1'b0, 0, 32'd42, cyc);
    run_op(2'd1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 32'h0, cyc);
    run_op(2'd1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 32'hFFFFFFFE, cyc);
    run_op(2'd2, 2'b00, 32'd100, 32'd7, 1'b0, 1'b0, 0, 32'd14, cyc);
    run_op(2'd3, 2'b00, 32'd100, 32'd7, 1'b0, 1'b0, 0, 32'd2, cyc);
    run_op(2'd2, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 0, 32'hFFFFFFFD, cyc);
    run_op(2'd3, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 0, 32'hFFFFFFFF, cyc);
    run_op(2'd2, 2'b00, 32'd5, 32'd0, 1'b0, 1'b0, 0, 32'hFFFFFFFF, cyc);
    run_op(2'd3, 2'b00, 32'd5, 32'd0, 1'b0, 1'b0, 0, 32'd5, cyc);
    run_op(2'd2, 2'b00, 32'd5, 32'd0, 1'b1, 1'b0, 0, 32'hFFFFFFFF, cyc);
    chk("dit_div_full", cyc >= 34, 1);
    run_op(2'd3, 2'b00, 32'd5, 32'd0, 1'b1, 1'b0, 0, 32'd5, cyc);
    chk("dit_rem_full", cyc >= 34, 1);
    drive_req(2'd2, 2'b00, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_keeps_en", div_en, 1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !req_ready; i++) begin
      seen |= rsp_valid;
      @(negedge clk);
    end
    chk("kill_no_rsp", seen | rsp_valid, 0);
    chk("kill_back_idle", req_ready, 1);
    run_op(2'd0, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 0, 32'd12, cyc);
    run_op(2'd0, 2'b00, 32'd7, 32'd6, 1'b0, 1'b0, 5, 32'd42, cyc);
    run_op(2'd0, 2'b00, 32'd2, 32'd5, 1'b0, 1'b1, 0, 32'd10, cyc);
    start_op(2'd0, 2'b00, 32'd1, 32'd1, 1'b0, 1'b0, cyc);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("resp_kill_idle", req_ready, 1);
    chk("resp_kill_no_valid", rsp_valid, 0);
    drive_req(2'd1, 2'b00, 32'h80000000, 32'd4, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; imd_we = 2'b11; imd_d[0] = 34'h3_1234_5678; imd_d[1] = 34'h3_1234_5678;
    @(negedge clk);
    rst = 1'b0; imd_we = 2'b00;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_en", mult_en | div_en | md_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_imd0", imd_q[0], 0);
    chk("midrst_imd1", imd_q[1], 0);
    run_op(2'd1, 2'b00, 32'h80000000, 32'd4, 1'b0, 1'b0, 0, 32'd2, cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
